// File: rtl/move_unit.sv
// -----------------------------------------------------------------------------
// move_unit -- register-transfer sequencer for a shared internal bus.
//
// Sequences either a MOVE (Ri <- Rj) or a SWAP (Ri <-> Rj through a temp
// register) by pulsing one-hot bus read/write enables, one step per cycle.
//
// Address map (AW = 6 bit operands):
//   0 .. NREG-1          general registers  (read/write)
//   NREG .. NDST-1       read/write ports   (read/write)
//   NDST .. NSRC-1       input ports        (read only)
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          request strobe, only looked at while idle
//   mode           0 = MOVE, 1 = SWAP
//   Ri, Rj         operand addresses
//   wr_en[NDST]    one-hot write enable of the target being loaded
//   rd_en[NSRC]    one-hot bus-drive enable of the source being read
//   tmp_wr/tmp_rd  load / drive the swap temp register
//   busy           not idle
//   done           one-cycle completion pulse
//   err            one-cycle illegal-operand pulse (with done)
// -----------------------------------------------------------------------------

// One-hot address decoder: bit k set when enabled and addr == k.
module move_unit_dec #(
  parameter int N  = 4,
  parameter int AW = 6
) (
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  output logic [N-1:0]  oh_o
);
  for (genvar k = 0; k < N; k++) begin : g_bit
    assign oh_o[k] = en_i && (addr_i == AW'(k));
  end
endmodule

module move_unit #(
  parameter  int NREG  = 4,
  parameter  int NPORT = 1,
  parameter  int NIN   = 1,
  localparam int NDST  = NREG + NPORT,
  localparam int NSRC  = NDST + NIN,
  localparam int AW    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [AW-1:0]   Ri,
  input  logic [AW-1:0]   Rj,
  output logic [NDST-1:0] wr_en,
  output logic [NSRC-1:0] rd_en,
  output logic            tmp_wr,
  output logic            tmp_rd,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XFER = 3'd1,
    S_SW1  = 3'd2,
    S_SW2  = 3'd3,
    S_SW3  = 3'd4,
    S_FIN  = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  typedef struct packed {
    logic          mode;
    logic [AW-1:0] ri;
    logic [AW-1:0] rj;
  } req_t;

  // One extra bit so the limits compare cleanly against the full operand,
  // keeping high operand bits part of the address (no aliasing).
  localparam logic [AW:0] NDST_L = (AW+1)'(NDST);
  localparam logic [AW:0] NSRC_L = (AW+1)'(NSRC);

  state_t state_q, state_d;
  req_t   req_q,   req_d;

  logic ri_dst, rj_dst, rj_src, legal;

  // Legality is judged on the live inputs in the accepting IDLE cycle; it
  // only steers the next state, never an output.
  always_comb begin
    ri_dst = {1'b0, Ri} < NDST_L;
    rj_dst = {1'b0, Rj} < NDST_L;
    rj_src = {1'b0, Rj} < NSRC_L;
    legal  = mode ? (ri_dst && rj_dst) : (ri_dst && rj_src);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          req_d = '{mode: mode, ri: Ri, rj: Rj};
          if (!legal)         state_d = S_ERR;
          else if (!mode)     state_d = S_XFER;
          else if (Ri == Rj)  state_d = S_FIN;   // swap with itself: nothing to move
          else                state_d = S_SW1;
        end
      end
      S_XFER:       state_d = S_FIN;
      S_SW1:        state_d = S_SW2;
      S_SW2:        state_d = S_SW3;
      S_SW3:        state_d = S_FIN;
      S_FIN, S_ERR: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: state + latched operands only. Each step names at most one
  // write target and one read source, so the one-hot decoders below make the
  // single-enable property structural.
  // ---------------------------------------------------------------------------
  logic          wr_sel, rd_sel;
  logic [AW-1:0] wr_addr, rd_addr;

  always_comb begin
    wr_sel  = 1'b0;
    rd_sel  = 1'b0;
    wr_addr = req_q.ri;
    rd_addr = req_q.rj;
    tmp_wr  = 1'b0;
    tmp_rd  = 1'b0;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_XFER: begin            // Ri <- Rj
        wr_sel = 1'b1;
        rd_sel = 1'b1;
      end
      S_SW1: begin             // tmp <- Ri
        rd_sel  = 1'b1;
        rd_addr = req_q.ri;
        tmp_wr  = 1'b1;
      end
      S_SW2: begin             // Ri <- Rj
        wr_sel = 1'b1;
        rd_sel = 1'b1;
      end
      S_SW3: begin             // Rj <- tmp
        wr_sel  = 1'b1;
        wr_addr = req_q.rj;
        tmp_rd  = 1'b1;
      end
      S_FIN: done = 1'b1;
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
    // Keep everything quiet while reset is held, including the cycle in which
    // it first arrives, so an aborted sequence emits no further pulses.
    if (reset) begin
      wr_sel = 1'b0;
      rd_sel = 1'b0;
      tmp_wr = 1'b0;
      tmp_rd = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
    end
  end

  move_unit_dec #(.N(NDST), .AW(AW)) u_wr_dec (
    .en_i   (wr_sel),
    .addr_i (wr_addr),
    .oh_o   (wr_en)
  );

  move_unit_dec #(.N(NSRC), .AW(AW)) u_rd_dec (
    .en_i   (rd_sel),
    .addr_i (rd_addr),
    .oh_o   (rd_en)
  );

  // Sanity properties on the bus protocol.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(wr_en)) else $error("multiple wr_en bits");
      assert ($onehot0(rd_en)) else $error("multiple rd_en bits");
      assert (!(tmp_rd && (|rd_en))) else $error("bus contention tmp_rd/rd_en");
      assert (!(err && !done)) else $error("err without done");
      assert (!((state_q == S_XFER) && req_q.mode)) else $error("XFER in swap mode");
    end
  end

endmodule

// File: tb/tb_move_unit.sv
module tb_move_unit;
  localparam int NREG  = 4;
  localparam int NPORT = 1;
  localparam int NIN   = 1;
  localparam int NDST  = NREG + NPORT;
  localparam int NSRC  = NDST + NIN;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            mode;
  logic [5:0]      Ri, Rj;
  logic [NDST-1:0] wr_en;
  logic [NSRC-1:0] rd_en;
  logic            tmp_wr, tmp_rd, busy, done, err;

  move_unit #(.NREG(NREG), .NPORT(NPORT), .NIN(NIN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .Ri     (Ri),
    .Rj     (Rj),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .tmp_wr (tmp_wr),
    .tmp_rd (tmp_rd),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Observed cycle: {wr_en[4:0], rd_en[5:0], tmp_wr, tmp_rd, busy, done, err}
  wire [15:0] obs = {wr_en, rd_en, tmp_wr, tmp_rd, busy, done, err};

  int n_cmp = 0;
  int n_bad = 0;

  // Expected output of each remaining cycle of the operation in flight;
  // empty means the unit is idle.
  logic [15:0] q[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input int wr, input int rd, input bit tw,
                                     input bit tr, input bit bz, input bit dn, input bit er);
    return {5'(wr), 6'(rd), tw, tr, bz, dn, er};
  endfunction

  // Reference: turn a request into its cycle-by-cycle bus schedule.
  function automatic void build(input bit md, input int ri, input int rj);
    bit ok;
    logic [15:0] fin;
    fin = pk(0, 0, 0, 0, 1, 1, 0);
    ok  = md ? (ri < NDST && rj < NDST) : (ri < NDST && rj < NSRC);
    if (!ok) q.push_back(pk(0, 0, 0, 0, 1, 1, 1));
    else if (!md) begin
      q.push_back(pk(1 << ri, 1 << rj, 0, 0, 1, 0, 0));
      q.push_back(fin);
    end else if (ri == rj) q.push_back(fin);
    else begin
      q.push_back(pk(0, 1 << ri, 1, 0, 1, 0, 0));
      q.push_back(pk(1 << ri, 1 << rj, 0, 0, 1, 0, 0));
      q.push_back(pk(1 << rj, 0, 0, 1, 1, 0, 0));
      q.push_back(fin);
    end
  endfunction

  // Check the current cycle, then present the inputs for the next edge.
  task automatic step(input string tag, input bit st, input bit md, input int ri, input int rj);
    logic [15:0] e;
    bit was_idle;
    @(negedge clk);
    e = (q.size() != 0) ? q[0] : 16'h0;
    chk(tag, obs, e);
    was_idle = (q.size() == 0);
    if (!was_idle) void'(q.pop_front());
    start = st; mode = md; Ri = 6'(ri); Rj = 6'(rj);
    if (was_idle && st) build(md, ri, rj);
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0);
  endtask

  // Reset with a legal start presented at the same edge; reset must win.
  task automatic do_reset(input string tag);
    @(negedge clk);
    chk({tag, "_pre"}, obs, (q.size() != 0) ? q[0] : 16'h0);
    reset = 1; start = 1; mode = 0; Ri = 6'd1; Rj = 6'd2;
    q.delete();
    @(negedge clk);
    chk({tag, "_in"}, obs, 16'h0);
    reset = 0; start = 0;
  endtask

  initial begin
    reset = 1; start = 1; mode = 1; Ri = 6'd0; Rj = 6'd4;
    @(negedge clk); chk("reset0", obs, 16'h0);
    @(negedge clk); chk("reset1", obs, 16'h0);
    reset = 0; start = 0;

    // MOVE R2 <- P0-in (5)
    step("mv25", 1, 0, 2, 5);   idle_n("mv25", 3);
    // SWAP R0 <-> P0 (4)
    step("sw04", 1, 1, 0, 4);   idle_n("sw04", 5);
    // illegal destinations
    step("mv50", 1, 0, 5, 0);   idle_n("mv50", 2);
    step("sw15", 1, 1, 1, 5);   idle_n("sw15", 2);
    step("mv40", 1, 0, 40, 1);  idle_n("mv40", 2);
    step("mv1_40", 1, 0, 1, 40); idle_n("mv1_40", 2);
    // degenerate cases
    step("sw33", 1, 1, 3, 3);   idle_n("sw33", 2);
    step("mv22", 1, 0, 2, 2);   idle_n("mv22", 3);
    step("mv45", 1, 0, 4, 5);   idle_n("mv45", 3);

    // start held high, operands changing every cycle
    for (int i = 0; i < 40; i++)
      if (i % 2 == 0) step("held", 1, 0, 0, 5);
      else            step("held", 1, 1, 1, 2);
    idle_n("held", 5);

    // reset while in SW2, then a normal MOVE
    step("rst_sw", 1, 1, 0, 4);
    step("rst_sw", 0, 0, 0, 0);
    do_reset("rst_sw2");
    step("post_rst", 1, 0, 3, 1); idle_n("post_rst", 3);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int ri, rj;
      ri = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
      rj = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
      if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
      else step("rnd", $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), ri, rj);
    end
    idle_n("drain", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
